uart_rx_port: RTL

//  Serial receiver (8N1, LSB first) that feeds one input port of the monocycle CPU

---
 rtl/uart_rx_port_if.sv | 31 +++
 rtl/uart_rx_port.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_port_if.sv
// Signal bundle between the 8N1 serial receiver and the CPU input port / interrupt line.
// The receiver uses the slave modport; the line driver and CPU side use master.
interface uart_rx_port_if;
  logic       rx;
  logic       ack;
  logic [7:0] data;
  logic       int_req;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;

  modport slave (
    input  rx,
    input  ack,
    output data,
    output int_req,
    output rx_valid,
    output overrun,
    output frame_err
  );

  modport master (
    output rx,
    output ack,
    input  data,
    input  int_req,
    input  rx_valid,
    input  overrun,
    input  frame_err
  );
endinterface

// File: rtl/uart_rx_port.sv
// 8N1 LSB-first serial receiver feeding one CPU input port, with a one-cycle interrupt
// pulse per good byte and a level-to-edge acknowledge from a CPU output-port bit.
module uart_rx_port #(
  parameter int unsigned DIVISOR = 434
) (
  input logic           clk,
  input logic           reset,
  uart_rx_port_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(DIVISOR);
  localparam logic [CntW-1:0] CntLast = CntW'(DIVISOR - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(DIVISOR / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            int_req_q, int_req_d;
  logic            rx_valid_q, rx_valid_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;

  logic            rx_meta_q, rs_q;
  logic            ack_q;
  logic            ack_rise;

  assign ack_rise = bus.ack & ~ack_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    int_req_d   = 1'b0;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;

    if (ack_rise) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rs_q) begin
          state_d = StStart;
        end
      end

      // Half-bit check of the start bit; later samples then land mid-bit.
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rs_q) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shreg_d = {rs_q, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d   = StStop;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      // A completion in the same cycle as ack_rise wins: the old byte counts as consumed.
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rs_q) begin
            state_d     = StIdle;
            data_d      = shreg_q;
            int_req_d   = 1'b1;
            rx_valid_d  = 1'b1;
            frame_err_d = 1'b0;
            if (rx_valid_q && !ack_rise) begin
              overrun_d = 1'b1;
            end
          end else begin
            state_d     = StWaitIdle;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      // Hold off during a break so a long low line cannot look like a new start bit.
      StWaitIdle: begin
        cnt_d = '0;
        if (rs_q) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      int_req_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_meta_q   <= 1'b1;
      rs_q        <= 1'b1;
      ack_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      int_req_q   <= int_req_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_meta_q   <= bus.rx;
      rs_q        <= rx_meta_q;
      ack_q       <= bus.ack;
    end
  end

  assign bus.data      = data_q;
  assign bus.int_req   = int_req_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;

endmodule
